button_event_gen: RTL and testbench

//  Conditions raw btnU/btnD/btnS pads into clean, queued button events for the game control logic.

---
 rtl/button_event_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_button_event_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Button conditioning for the game tick: sync, debounce, press/long-press classification and an event queue.
// Define AUTO_REPEAT_EN to make held Up/Down re-issue events after LONG_TICKS, every REPEAT_TICKS.
module button_event_gen #(
  parameter int DEB_SAMPLES  = 2,
  parameter int LONG_TICKS   = 20,
  parameter int REPEAT_TICKS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_20Hz,
  input  logic                          rst,
  input  logic                          btnU_raw,
  input  logic                          btnD_raw,
  input  logic                          btnS_raw,
  input  logic                          ev_ack,
  output logic                          ev_valid,
  output logic [2:0]                    ev_code,
  output logic [2:0]                    btn_level,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DW = $clog2(DEB_SAMPLES + 1);
  localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_UP     = 3'd1;
  localparam logic [2:0] EV_DOWN   = 3'd2;
  localparam logic [2:0] EV_SELECT = 3'd3;
  localparam logic [2:0] EV_LONG   = 3'd4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LONG_DONE = 2'd2} s_state_t;

  logic [2:0]    raw_s, sync1_r, sync2_r, level_r, flip_s, rise_s;
  logic [DW-1:0] deb_cnt_r [3];
  logic          s_fall_s;
  s_state_t      s_state_r, s_state_s;
  logic [HW-1:0] s_hold_r, s_hold_s;
  logic          set_sel_s, set_long_s;
  logic [1:0]    set_ud_s;
  logic [3:0]    pend_r, pend_s, win_s, set_s;
  logic [2:0]    win_code_s;
  logic          pop_s, push_s, drop_s, full_s;
  logic [2:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;

  assign raw_s = {btnS_raw, btnD_raw, btnU_raw};

  // Two-flop synchroniser for all three pads.
  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // A level flips on the tick its disagreement count would reach DEB_SAMPLES.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flip_s[i] = (sync2_r[i] != level_r[i]) && (deb_cnt_r[i] == DW'(DEB_SAMPLES - 1));
    end
  end
  assign rise_s   = flip_s & ~level_r;
  assign s_fall_s = flip_s[2] & level_r[2];

  // Debounce counters and debounced levels.
  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      level_r <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= '0;
    end else begin
      level_r <= level_r ^ flip_s;
      for (int i = 0; i < 3; i++) begin
        if ((sync2_r[i] != level_r[i]) && !flip_s[i]) deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
        else                                          deb_cnt_r[i] <= '0;
      end
    end
  end

  // Select classifier: short press on release, long press once when the hold reaches LONG_TICKS.
  always_comb begin
    s_state_s  = s_state_r;
    s_hold_s   = s_hold_r;
    set_sel_s  = 1'b0;
    set_long_s = 1'b0;
    case (s_state_r)
      S_IDLE: begin
        if (rise_s[2]) begin
          s_state_s = S_HELD;
          s_hold_s  = '0;
        end else begin
          s_state_s = S_IDLE;
        end
      end
      S_HELD: begin
        if (s_fall_s) begin
          s_state_s = S_IDLE;
          set_sel_s = 1'b1;
        end else if (s_hold_r == HW'(LONG_TICKS - 1)) begin
          s_state_s  = S_LONG_DONE;
          s_hold_s   = HW'(LONG_TICKS);
          set_long_s = 1'b1;
        end else if (s_hold_r < HW'(LONG_TICKS)) begin
          s_hold_s = s_hold_r + HW'(1);
        end else begin
          s_hold_s = s_hold_r;
        end
      end
      S_LONG_DONE: begin
        if (s_fall_s) s_state_s = S_IDLE;
        else          s_state_s = S_LONG_DONE;
      end
      default: begin
        s_state_s = S_IDLE;
        s_hold_s  = '0;
      end
    endcase
  end

  // Select classifier state register.
  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      s_state_r <= S_IDLE;
      s_hold_r  <= '0;
    end else begin
      s_state_r <= s_state_s;
      s_hold_r  <= s_hold_s;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [HW-1:0] ud_hold_r [2];
  logic [HW-1:0] ud_hold_s [2];
  logic [1:0]    rep_s;

  // Hold counters cycle through LONG_TICKS..LONG_TICKS+REPEAT_TICKS-1, firing on each entry to LONG_TICKS.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_s[i]     = 1'b0;
      ud_hold_s[i] = ud_hold_r[i];
      if (rise_s[i]) begin
        ud_hold_s[i] = '0;
      end else if (level_r[i] && !flip_s[i]) begin
        if (ud_hold_r[i] == HW'(LONG_TICKS + REPEAT_TICKS - 1)) begin
          ud_hold_s[i] = HW'(LONG_TICKS);
          rep_s[i]     = 1'b1;
        end else begin
          ud_hold_s[i] = ud_hold_r[i] + HW'(1);
          rep_s[i]     = (ud_hold_r[i] == HW'(LONG_TICKS - 1));
        end
      end else begin
        ud_hold_s[i] = ud_hold_r[i];
      end
    end
  end

  // Up/Down hold counter registers.
  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      ud_hold_r[0] <= '0;
      ud_hold_r[1] <= '0;
    end else begin
      ud_hold_r[0] <= ud_hold_s[0];
      ud_hold_r[1] <= ud_hold_s[1];
    end
  end

  assign set_ud_s = rise_s[1:0] | rep_s;
`else
  assign set_ud_s = rise_s[1:0];
`endif

  // Fixed-priority pick of one pending event per tick; a re-set of a pending flag merges.
  always_comb begin
    win_s      = 4'b0000;
    win_code_s = EV_NONE;
    if (pend_r[3]) begin
      win_s      = 4'b1000;
      win_code_s = EV_LONG;
    end else if (pend_r[2]) begin
      win_s      = 4'b0100;
      win_code_s = EV_SELECT;
    end else if (pend_r[0]) begin
      win_s      = 4'b0001;
      win_code_s = EV_UP;
    end else if (pend_r[1]) begin
      win_s      = 4'b0010;
      win_code_s = EV_DOWN;
    end else begin
      win_s      = 4'b0000;
      win_code_s = EV_NONE;
    end
  end

  assign set_s  = {set_long_s, set_sel_s, set_ud_s[1], set_ud_s[0]};
  assign pend_s = (pend_r & ~win_s) | set_s;
  assign full_s = (count_r == CW'(FIFO_DEPTH));
  assign pop_s  = ev_valid && ev_ack;
  assign push_s = (|win_s) && (!full_s || pop_s);
  assign drop_s = (|win_s) && full_s && !pop_s;

  // Pending flags, event queue storage/pointers and sticky overflow.
  always_ff @(posedge clk_20Hz or posedge rst) begin
    if (rst) begin
      pend_r   <= 4'b0000;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= EV_NONE;
    end else begin
      pend_r   <= pend_s;
      overflow <= overflow | drop_s;
      if (push_s) begin
        mem_r[wr_ptr_r] <= win_code_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign ev_valid   = (count_r != CW'(0));
  assign ev_code    = ev_valid ? mem_r[rd_ptr_r] : EV_NONE;
  assign fifo_count = count_r;
  assign btn_level  = level_r;

endmodule

// File: tb/tb_button_event_gen.sv
// Randomised bench for button_event_gen, scored against an event-level reference model.
module tb_button_event_gen;
  localparam int DEB   = 2;
  localparam int LONG  = 20;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  logic       clk_20Hz = 1'b0;
  logic       rst = 1'b1;
  logic       btnU_raw = 1'b0, btnD_raw = 1'b0, btnS_raw = 1'b0, ev_ack = 1'b0;
  logic       ev_valid, overflow;
  logic [2:0] ev_code, btn_level, fifo_count;

  int checks = 0;
  int failures = 0;

  always #5 clk_20Hz = ~clk_20Hz;

  button_event_gen #(.DEB_SAMPLES(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_20Hz(clk_20Hz), .rst(rst), .btnU_raw(btnU_raw), .btnD_raw(btnD_raw), .btnS_raw(btnS_raw),
    .ev_ack(ev_ack), .ev_valid(ev_valid), .ev_code(ev_code), .btn_level(btn_level),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync delay line, debounced levels, hold durations, pending set, event queue.
  bit [2:0] m_s1, m_s2, m_lvl;
  int       m_deb [3];
  int       m_hold [3];
  bit       m_long;
  bit [4:1] m_pend;
  int       q [$];
  bit       m_ovf;

  function automatic void model_reset();
    m_s1 = 3'b000; m_s2 = 3'b000; m_lvl = 3'b000;
    for (int i = 0; i < 3; i++) begin m_deb[i] = 0; m_hold[i] = 0; end
    m_long = 1'b0; m_pend = 4'b0000; q.delete(); m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit [2:0] raw, input bit ack);
    bit [2:0] rise, fall;
    int win;
    bit pop;
    pop = (q.size() > 0) && ack;
    win = 0;
    if (m_pend[4]) win = 4;
    else if (m_pend[3]) win = 3;
    else if (m_pend[1]) win = 1;
    else if (m_pend[2]) win = 2;
    if (pop) void'(q.pop_front());
    if (win != 0) begin
      if (q.size() < DEPTH) q.push_back(win);
      else m_ovf = 1'b1;
      m_pend[win] = 1'b0;
    end
    rise = 3'b000; fall = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_deb[i]++;
        if (m_deb[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_deb[i] = 0;
          if (m_lvl[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
        end
      end else begin
        m_deb[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) begin
        m_pend[i+1] = 1'b1;
        m_hold[i] = 0;
      end else if (m_lvl[i] && !fall[i]) begin
        m_hold[i]++;
`ifdef AUTO_REPEAT_EN
        if (m_hold[i] >= LONG && ((m_hold[i] - LONG) % REP) == 0) m_pend[i+1] = 1'b1;
`endif
      end
    end
    if (rise[2]) begin
      m_hold[2] = 0; m_long = 1'b0;
    end else if (fall[2]) begin
      if (!m_long) m_pend[3] = 1'b1;
    end else if (m_lvl[2]) begin
      m_hold[2]++;
      if (m_hold[2] == LONG) begin m_pend[4] = 1'b1; m_long = 1'b1; end
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, int'(ev_valid), int'(q.size() > 0));
    check({tag, ".code"},  int'(ev_code), (q.size() > 0) ? q[0] : 0);
    check({tag, ".level"}, int'(btn_level), int'(m_lvl));
    check({tag, ".count"}, int'(fifo_count), q.size());
    check({tag, ".ovf"},   int'(overflow), int'(m_ovf));
  endtask

  int       rem [3];
  bit [2:0] raw_v;

  function automatic int pick_duration();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return $urandom_range(1, 2);
    else if (r < 6) return $urandom_range(3, 12);
    else return $urandom_range(20, 45);
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk_20Hz);
    @(negedge clk_20Hz);
    check_outputs("reset");
    rst = 1'b0;

    // Fixed-latency press: Up raised before edge 1, no ack.
    btnU_raw = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk_20Hz);
      check("lat.valid", int'(ev_valid), (e >= 5) ? 1 : 0);
      check("lat.level", int'(btn_level), (e >= 4) ? 1 : 0);
      check("lat.count", int'(fifo_count), (e >= 5) ? 1 : 0);
      check("lat.code",  int'(ev_code), (e >= 5) ? 1 : 0);
    end
    rst = 1'b1;
    btnU_raw = 1'b0;
    #1;
    check("rst.valid", int'(ev_valid), 0);
    check("rst.count", int'(fifo_count), 0);
    @(negedge clk_20Hz);
    rst = 1'b0;
    model_reset();

    raw_v = 3'b000;
    for (int i = 0; i < 3; i++) rem[i] = pick_duration();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          raw_v[i] = ~raw_v[i];
          rem[i] = pick_duration();
        end else begin
          rem[i]--;
        end
      end
      {btnS_raw, btnD_raw, btnU_raw} = raw_v;
      case ((cyc / 250) % 4)
        0:       ev_ack = 1'b0;
        1:       ev_ack = ($urandom_range(0, 3) == 0);
        2:       ev_ack = 1'b1;
        default: ev_ack = $urandom_range(0, 1) == 1;
      endcase
      model_step(raw_v, ev_ack);
      @(negedge clk_20Hz);
      check_outputs("run");
      if (cyc == 1100 || cyc == 2240) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("midrst");
        @(negedge clk_20Hz);
        check_outputs("midrst_hold");
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
